// File: rtl/mc_alu_pkg.sv
// Shared definitions for the multi-cycle ALU: ALU_Ctl encodings and FSM states.
package mc_alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

endpackage

// File: rtl/mc_alu_muldiv.sv
// Iterative unsigned multiply (shift-add) / restoring divide, one bit per cycle.
module mc_alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_mul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt;
  logic             mul_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] hi_nx;
  logic [WIDTH-1:0] lo_nx;

  // done marks the edge that performs the final iteration
  assign done = busy && (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    add_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd_q} : '0);
    shifted = {hi, lo[WIDTH-1]};
    diff    = shifted - {1'b0, opnd_q};
    hi_nx   = hi;
    lo_nx   = lo;
    if (mul_q) begin
      // {hi,lo} holds partial product over the not-yet-consumed multiplier bits
      hi_nx = add_sum[WIDTH:1];
      lo_nx = {add_sum[0], lo[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      hi_nx = diff[WIDTH-1:0];
      lo_nx = {lo[WIDTH-2:0], 1'b1};
    end else begin
      hi_nx = shifted[WIDTH-1:0];
      lo_nx = {lo[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      cnt    <= '0;
      mul_q  <= 1'b0;
      opnd_q <= '0;
      hi     <= '0;
      lo     <= '0;
    end else if (!busy) begin
      if (start) begin
        busy   <= 1'b1;
        cnt    <= '0;
        mul_q  <= op_mul;
        hi     <= '0;
        lo     <= op_mul ? b : a;
        opnd_q <= op_mul ? a : b;
      end
    end else begin
      hi  <= hi_nx;
      lo  <= lo_nx;
      cnt <= cnt + 1'b1;
      if (done) begin
        busy <= 1'b0;
        cnt  <= '0;
      end
    end
  end

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle logic ops plus iterative MULTU/DIVU, results registered on done.
module mc_alu
  import mc_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CTL_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [CTL_W-1:0] ALU_Ctl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALU_Out,
  output logic [WIDTH-1:0] HI,
  output logic             Zero_Flag,
  output logic             Overflow,
  output logic             Div_Zero
);

  localparam logic [CTL_W-1:0] C_AND   = CTL_W'(OP_AND);
  localparam logic [CTL_W-1:0] C_OR    = CTL_W'(OP_OR);
  localparam logic [CTL_W-1:0] C_ADD   = CTL_W'(OP_ADD);
  localparam logic [CTL_W-1:0] C_SUB   = CTL_W'(OP_SUB);
  localparam logic [CTL_W-1:0] C_SLT   = CTL_W'(OP_SLT);
  localparam logic [CTL_W-1:0] C_NOR   = CTL_W'(OP_NOR);
  localparam logic [CTL_W-1:0] C_MULTU = CTL_W'(OP_MULTU);
  localparam logic [CTL_W-1:0] C_DIVU  = CTL_W'(OP_DIVU);

  state_t           state, state_nx;
  logic [CTL_W-1:0] op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             accept, is_mul, is_div_nz, md_start, md_done;
  logic [WIDTH-1:0] md_hi, md_lo;
  logic [WIDTH-1:0] sum, dif;
  logic [WIDTH-1:0] res_out, res_hi;
  logic             res_ovf, res_dz;

  assign accept    = start && (state == IDLE);
  assign is_mul    = (ALU_Ctl == C_MULTU);
  assign is_div_nz = (ALU_Ctl == C_DIVU) && (B != '0);
  assign md_start  = accept && (is_mul || is_div_nz);

  mc_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .op_mul (is_mul),
    .a      (A),
    .b      (B),
    .busy   (busy),
    .done   (md_done),
    .hi     (md_hi),
    .lo     (md_lo)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (start) state_nx = is_mul ? MUL : (is_div_nz ? DIV : FIN);
      MUL, DIV: if (md_done) state_nx = FIN;
      FIN:      state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q <= ALU_Ctl;
        a_q  <= A;
        b_q  <= B;
      end
    end
  end

  // Result is evaluated in FIN from the operands latched at the start edge
  always_comb begin
    sum     = a_q + b_q;
    dif     = a_q - b_q;
    res_out = '0;
    res_hi  = HI;
    res_ovf = 1'b0;
    res_dz  = 1'b0;
    case (op_q)
      C_AND: res_out = a_q & b_q;
      C_OR:  res_out = a_q | b_q;
      C_NOR: res_out = ~(a_q | b_q);
      C_ADD: begin
        res_out = sum;
        res_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      C_SUB: begin
        res_out = dif;
        res_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif[WIDTH-1] != a_q[WIDTH-1]);
      end
      C_SLT: res_out = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      C_MULTU: begin
        res_out = md_lo;
        res_hi  = md_hi;
      end
      C_DIVU: begin
        if (b_q == '0) begin
          res_out = '1;
          res_hi  = a_q;
          res_dz  = 1'b1;
        end else begin
          res_out = md_lo;
          res_hi  = md_hi;
        end
      end
      default: res_out = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done      <= 1'b0;
      ALU_Out   <= '0;
      HI        <= '0;
      Zero_Flag <= 1'b1;
      Overflow  <= 1'b0;
      Div_Zero  <= 1'b0;
    end else begin
      done <= (state == FIN);
      if (state == FIN) begin
        ALU_Out   <= res_out;
        HI        <= res_hi;
        Zero_Flag <= (res_out == '0);
        Overflow  <= res_ovf;
        Div_Zero  <= res_dz;
      end
    end
  end

endmodule
